// File: rtl/logic_reduce_acc_amisha_pkg.sv
// Shared encodings for the logic-reduction accumulator.
// Mode codes and FSM state codes used by the top and the lane reducer.
package logic_reduce_acc_amisha_pkg;

   typedef enum logic [1:0] {
      MODE_AND  = 2'b00,
      MODE_OR   = 2'b01,
      MODE_XOR  = 2'b10,
      MODE_NAND = 2'b11
   } mode_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_ACC  = 2'b01,
      ST_HOLD = 2'b10
   } state_e;

endpackage

// File: rtl/logic_reduce_acc_amisha_lane_reduce.sv
// lane_reduce_amisha: combinational LANES x WIDTH bitwise reducer.
// NAND reduces with AND; the final inversion happens after packet folding.
module lane_reduce_amisha
   import logic_reduce_acc_amisha_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int LANES = 3
) (
   input  mode_e                    mode,
   input  logic [LANES*WIDTH-1:0]   data,
   output logic [WIDTH-1:0]         red
);

   always_comb begin
      red = data[WIDTH-1:0];
      for (int k = 1; k < LANES; k++) begin
         unique case (mode)
            MODE_AND,
            MODE_NAND: red = red & data[k*WIDTH +: WIDTH];
            MODE_OR:   red = red | data[k*WIDTH +: WIDTH];
            MODE_XOR:  red = red ^ data[k*WIDTH +: WIDTH];
            default:   red = red & data[k*WIDTH +: WIDTH];
         endcase
      end
   end

endmodule

// File: rtl/logic_reduce_acc_amisha.sv
// Registered multi-lane logic gate that folds each beat into a packet result.
// Optional beat counter on out_beats_amisha when LOGIC_REDUCE_BEATCNT_EN is defined.
module logic_reduce_acc_amisha
   import logic_reduce_acc_amisha_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int LANES = 3,
   parameter int CNT_W = 8
) (
   input  logic                   clk_amisha,
   input  logic                   rst_n_amisha,
   input  logic [1:0]             mode_amisha,
   input  logic                   in_valid_amisha,
   output logic                   in_ready_amisha,
   input  logic [LANES*WIDTH-1:0] in_data_amisha,
   input  logic                   in_last_amisha,
   output logic                   out_valid_amisha,
   input  logic                   out_ready_amisha,
`ifdef LOGIC_REDUCE_BEATCNT_EN
   output logic [CNT_W-1:0]       out_beats_amisha,
`endif
   output logic [WIDTH-1:0]       out_data_amisha
);

   if (LANES < 2 || CNT_W < 1) begin : g_bad_cfg
      $error("logic_reduce_acc_amisha: LANES must be >= 2, CNT_W >= 1");
   end

   state_e            state_q, state_d;
   mode_e             mode_q, eff_mode;
   logic [WIDTH-1:0]  acc_q, data_q;
   logic [WIDTH-1:0]  red, folded, result;
   logic              beat, first;

   assign in_ready_amisha  = (state_q != ST_HOLD);
   assign out_valid_amisha = (state_q == ST_HOLD);
   assign out_data_amisha  = data_q;

   assign beat     = in_valid_amisha & in_ready_amisha;
   assign first    = (state_q == ST_IDLE);
   assign eff_mode = first ? mode_e'(mode_amisha) : mode_q;

   lane_reduce_amisha #(
      .WIDTH (WIDTH),
      .LANES (LANES)
   ) u_lane_reduce (
      .mode (eff_mode),
      .data (in_data_amisha),
      .red  (red)
   );

   always_comb begin
      folded = red;
      if (!first) begin
         unique case (eff_mode)
            MODE_AND,
            MODE_NAND: folded = acc_q & red;
            MODE_OR:   folded = acc_q | red;
            MODE_XOR:  folded = acc_q ^ red;
            default:   folded = acc_q & red;
         endcase
      end
      result = (eff_mode == MODE_NAND) ? ~folded : folded;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: begin
            if (in_valid_amisha)
               state_d = in_last_amisha ? ST_HOLD : ST_ACC;
         end
         ST_ACC: begin
            if (in_valid_amisha && in_last_amisha)
               state_d = ST_HOLD;
         end
         ST_HOLD: begin
            if (out_ready_amisha)
               state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_amisha or negedge rst_n_amisha) begin
      if (!rst_n_amisha) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk_amisha or negedge rst_n_amisha) begin
      if (!rst_n_amisha) begin
         mode_q <= MODE_AND;
         acc_q  <= '0;
         data_q <= '0;
      end else if (beat) begin
         acc_q <= folded;
         if (first)
            mode_q <= eff_mode;
         if (in_last_amisha)
            data_q <= result;
      end
   end

`ifdef LOGIC_REDUCE_BEATCNT_EN
   logic [CNT_W-1:0] cnt_q, cnt_nxt, beats_q;

   // Count restarts on the first beat and saturates rather than wrapping.
   always_comb begin
      if (first)
         cnt_nxt = CNT_W'(1);
      else if (&cnt_q)
         cnt_nxt = cnt_q;
      else
         cnt_nxt = cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk_amisha or negedge rst_n_amisha) begin
      if (!rst_n_amisha) begin
         cnt_q   <= '0;
         beats_q <= '0;
      end else if (beat) begin
         cnt_q <= cnt_nxt;
         if (in_last_amisha)
            beats_q <= cnt_nxt;
      end
   end

   assign out_beats_amisha = beats_q;
`endif

endmodule
